tpx3_pkt_assembler: RTL
=======================

// Module: tpx3_pkt_assembler
// PURPOSE
//  Consumer of the RX core's 32-bit FWFT FIFO port (FIFO_READ/FIFO_EMPTY/FIFO_DATA).
//  Pairs high/low 24-bit halves into one 48-bit Timepix3 packet and emits it on a valid/ready stream.
//  Filters words from other identifiers and malformed pairs, with saturating error counters.
//  Sits between tpx3_rx and the per-chip packet decoder; single clock domain (BUS_CLK).
// PARAMETERS
//  DATA_IDENTIFIER  0     4-bit stream ID expected in FIFO_DATA[31:28]
//  CNT_WIDTH        16    width of each saturating error counter
//  TIMEOUT_CYCLES   1024  WAIT_LO abandon limit (used only with TPX3_PKT_TIMEOUT_EN)
// PORTS
//  BUS_CLK      in   1   sole clock
//  BUS_RST      in   1   synchronous, active-high reset
//  FIFO_EMPTY   in   1   RX FIFO empty; FIFO_DATA valid when low (first-word-fall-through)
//  FIFO_DATA    in   32  [31:28] ID, [24] 1=high half (pkt[47:24]) 0=low half, [23:0] payload
//  FIFO_READ    out  1   pop strobe, one word per cycle
//  PKT_VALID    out  1   48-bit packet available
//  PKT_READY    in   1   downstream accepts when PKT_VALID&PKT_READY
//  PKT_DATA     out  48  {high payload, low payload}
//  ERR_ID       out  CNT_WIDTH  words dropped for ID mismatch
//  ERR_ORPHAN   out  CNT_WIDTH  low halves without preceding high half
//  ERR_REPLACE  out  CNT_WIDTH  high halves overwritten by a second high half
//  CNT_CLR      in   1   synchronous clear of all ERR_* counters
// BEHAVIOUR
//  Reset: FSM=WAIT_HI, FIFO_READ=0, PKT_VALID=0, PKT_DATA=0, all ERR_*=0; half-packet discarded.
//  FIFO_READ = !FIFO_EMPTY && !(PKT_VALID && !PKT_READY); combinational, never pops while output stalled.
//  Every popped word classified same cycle; ID mismatch -> dropped, ERR_ID++, state unchanged.
//  WAIT_HI: hi word -> latch payload, go WAIT_LO; lo word -> drop, ERR_ORPHAN++.
//  WAIT_LO: lo word -> PKT_DATA<={hi,lo}, PKT_VALID=1 next cycle, go WAIT_HI;
//           hi word -> replace latched half, ERR_REPLACE++, stay WAIT_LO.
//  Latency: low-half pop at cycle N -> PKT_VALID at N+1. Throughput: 1 pkt / 2 words, no bubbles
//   when PKT_READY held high (output reg reloads in the cycle it is consumed).
//  PKT_VALID stays high and PKT_DATA stable until accepted; packets never dropped once valid.
//  Counters saturate at all-ones; CNT_CLR wins over simultaneous increment; BUS_RST wins over all.
//  FIFO_EMPTY rising mid-pair: stay WAIT_LO indefinitely (unless timeout feature).
// CONFIGURATION
//  TPX3_PKT_TIMEOUT_EN defined: cycle counter runs in WAIT_LO, reset on every pop;
//   at TIMEOUT_CYCLES consecutive idle cycles -> discard half, go WAIT_HI, ERR_REPLACE++.
//  Not defined: no counter, WAIT_LO waits forever; TIMEOUT_CYCLES ignored.
// STRUCTURE
//  Package tpx3_pkt_pkg: field positions (ID_MSB/LSB=31/28, HALF_BIT=24, PAYLOAD_W=24, PKT_W=48),
//   FSM state enum {WAIT_HI, WAIT_LO}.
//  Sub-module tpx3_sat_cnt (CNT_WIDTH, inc, clr, sync rst) instantiated three times.
//  FSM, pop logic and output register stay in this module.
// TESTING
//  hi 0x0ABCDE, lo 0x123456, ID match, READY=1 -> one packet 0x0ABCDE123456 at cycle after lo pop.
//  Two pairs back-to-back, READY low 5 cycles -> FIFO_READ=0 while stalled, both packets in order.
//  lo word first, then valid pair -> ERR_ORPHAN=1, exactly one packet output.
//  hi A, hi B, lo C -> packet {B,C}, ERR_REPLACE=1.
//  Word with ID=DATA_IDENTIFIER+1 between hi and lo -> ERR_ID=1, pair still assembled.
//  TPX3_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=16: hi then 16 empty cycles then lo -> no packet, ERR_REPLACE=1, ERR_ORPHAN=1.

Source files
------------

// File: rtl/tpx3_pkt_pkg.sv
// tpx3_pkt_pkg: field positions and FSM states shared by the Timepix3 packet assembler.
package tpx3_pkt_pkg;
    localparam int ID_MSB    = 31;
    localparam int ID_LSB    = 28;
    localparam int HALF_BIT  = 24;
    localparam int PAYLOAD_W = 24;
    localparam int PKT_W     = 48;
    typedef enum logic {WAIT_HI, WAIT_LO} state_t;
endpackage

// File: rtl/tpx3_sat_cnt.sv
// tpx3_sat_cnt: saturating event counter with synchronous clear; clear beats increment.
module tpx3_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_cnt
);
    logic [CNT_WIDTH-1:0] r_cnt;
    // count up until all-ones, then hold
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_cnt <= '0;
        else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/tpx3_pkt_assembler.sv
// tpx3_pkt_assembler: pairs high/low 24-bit halves from the RX FIFO into 48-bit packets.
// Optional macro TPX3_PKT_TIMEOUT_EN abandons a half packet after TIMEOUT_CYCLES idle cycles.
module tpx3_pkt_assembler
    import tpx3_pkt_pkg::*;
#(
    parameter logic [3:0] DATA_IDENTIFIER = 4'd0,
    parameter int         CNT_WIDTH       = 16,
    parameter int         TIMEOUT_CYCLES  = 1024
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 FIFO_EMPTY,
    input  logic [31:0]          FIFO_DATA,
    output logic                 FIFO_READ,
    output logic                 PKT_VALID,
    input  logic                 PKT_READY,
    output logic [PKT_W-1:0]     PKT_DATA,
    output logic [CNT_WIDTH-1:0] ERR_ID,
    output logic [CNT_WIDTH-1:0] ERR_ORPHAN,
    output logic [CNT_WIDTH-1:0] ERR_REPLACE,
    input  logic                 CNT_CLR
);
    state_t                 r_state, w_state_nxt;
    logic [PAYLOAD_W-1:0]   r_hi;
    logic                   r_pkt_valid;
    logic [PKT_W-1:0]       r_pkt_data;
    logic [PAYLOAD_W-1:0]   w_payload;
    logic                   w_id_ok, w_is_hi, w_take, w_timeout;
    logic                   w_pkt_load, w_inc_id, w_inc_orphan, w_inc_replace;
    logic                   w_unused;

    // never pop while the output register holds an unaccepted packet
    assign FIFO_READ = !BUS_RST && !FIFO_EMPTY && !(r_pkt_valid && !PKT_READY);
    assign w_id_ok   = FIFO_DATA[ID_MSB:ID_LSB] == DATA_IDENTIFIER;
    assign w_is_hi   = FIFO_DATA[HALF_BIT];
    assign w_payload = FIFO_DATA[PAYLOAD_W-1:0];
    assign w_take    = FIFO_READ && w_id_ok;
    assign w_inc_id  = FIFO_READ && !w_id_ok;
    assign w_unused  = &{1'b0, FIFO_DATA[ID_LSB-1:HALF_BIT+1], TIMEOUT_CYCLES > 0};

`ifdef TPX3_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] r_idle;
    // consecutive cycles without a pop while holding a high half
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || r_state != WAIT_LO || FIFO_READ) r_idle <= '0;
        else r_idle <= r_idle + 1'b1;
    end
    assign w_timeout = r_state == WAIT_LO && !FIFO_READ && r_idle == TW'(TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    // next state, packet load and error events from the word popped this cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_pkt_load    = 1'b0;
        w_inc_orphan  = 1'b0;
        w_inc_replace = 1'b0;
        if (r_state == WAIT_HI) begin
            w_state_nxt  = (w_take && w_is_hi) ? WAIT_LO : WAIT_HI;
            w_inc_orphan = w_take && !w_is_hi;
        end else begin
            w_pkt_load    = w_take && !w_is_hi;
            w_state_nxt   = (w_pkt_load || w_timeout) ? WAIT_HI : WAIT_LO;
            w_inc_replace = (w_take && w_is_hi) || w_timeout;
        end
    end

    // FSM state register
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) r_state <= WAIT_HI;
        else r_state <= w_state_nxt;
    end

    // latch the most recent high half (a second high half overwrites it)
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) r_hi <= '0;
        else if (w_take && w_is_hi) r_hi <= w_payload;
    end

    // output register: reloads in the same cycle the previous packet is accepted
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= '0;
        end else if (w_pkt_load) begin
            r_pkt_valid <= 1'b1;
            r_pkt_data  <= {r_hi, w_payload};
        end else if (PKT_READY) begin
            r_pkt_valid <= 1'b0;
        end
    end

    assign PKT_VALID = r_pkt_valid;
    assign PKT_DATA  = r_pkt_data;

    tpx3_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_id (
        .i_clk(BUS_CLK), .i_rst(BUS_RST), .i_inc(w_inc_id), .i_clr(CNT_CLR), .o_cnt(ERR_ID)
    );
    tpx3_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_orphan (
        .i_clk(BUS_CLK), .i_rst(BUS_RST), .i_inc(w_inc_orphan), .i_clr(CNT_CLR), .o_cnt(ERR_ORPHAN)
    );
    tpx3_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_replace (
        .i_clk(BUS_CLK), .i_rst(BUS_RST), .i_inc(w_inc_replace), .i_clr(CNT_CLR), .o_cnt(ERR_REPLACE)
    );
endmodule
